// File: rtl/core_pkg.sv
// Shared core types: OBI manager identifiers used by the bus arbiter and its ID FIFO.
package core_pkg;

  typedef logic obi_mgr_id_t;

  localparam obi_mgr_id_t OBI_MGR_FETCH = 1'b0;
  localparam obi_mgr_id_t OBI_MGR_DATA  = 1'b1;

  // With two managers the round-robin "other" port is simply the complement.
  function automatic obi_mgr_id_t obi_other_mgr(input obi_mgr_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of manager ids for granted-but-unanswered OBI transactions.
module obi_id_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  obi_mgr_id_t id_i,
  output obi_mgr_id_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  obi_mgr_id_t        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= id_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_bus_arbiter.sv
// Two-to-one OBI arbiter: fetch (port 0) and data (port 1) share one subordinate,
// zero added latency, responses routed back in order via an id FIFO.
module obi_bus_arbiter
  import core_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  input  logic        m0_rready_i,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  input  logic        m1_rready_i,
  output logic [31:0] m1_rdata_o,

  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  output logic        s_rready_o,
  input  logic [31:0] s_rdata_i
);

  obi_mgr_id_t last_id_q;
  obi_mgr_id_t lock_id_q;
  obi_mgr_id_t sel_arb;
  obi_mgr_id_t sel;
  obi_mgr_id_t fifo_head;
  logic        locked_q;
  logic        sel_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        addr_hs;

  always_comb begin
    sel_arb = OBI_MGR_FETCH;
    if (m0_req_i && m1_req_i) sel_arb = obi_other_mgr(last_id_q);
    else if (m1_req_i)        sel_arb = OBI_MGR_DATA;
  end

  // A stalled address phase keeps its port so the OBI address signals stay stable.
  assign sel     = locked_q ? lock_id_q : sel_arb;
  assign sel_req = (sel == OBI_MGR_DATA) ? m1_req_i : m0_req_i;

  assign s_rready_o = fifo_empty ? 1'b1 :
                      ((fifo_head == OBI_MGR_DATA) ? m1_rready_i : m0_rready_i);
  assign fifo_pop   = s_rvalid_i && s_rready_o && !fifo_empty;

  // A full FIFO still accepts a new grant in the cycle a response frees a slot.
  assign s_req_o = rst_n_i && sel_req && (!fifo_full || fifo_pop);
  assign addr_hs = s_req_o && s_gnt_i;

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      if (sel == OBI_MGR_DATA) begin
        s_addr_o  = m1_addr_i;
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_addr_o  = m0_addr_i;
        s_we_o    = m0_we_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  assign m0_gnt_o = addr_hs && (sel == OBI_MGR_FETCH);
  assign m1_gnt_o = addr_hs && (sel == OBI_MGR_DATA);

  assign m0_rvalid_o = s_rvalid_i && !fifo_empty && (fifo_head == OBI_MGR_FETCH);
  assign m1_rvalid_o = s_rvalid_i && !fifo_empty && (fifo_head == OBI_MGR_DATA);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      locked_q  <= 1'b0;
      lock_id_q <= OBI_MGR_FETCH;
      last_id_q <= OBI_MGR_DATA;
    end else begin
      locked_q  <= s_req_o && !s_gnt_i;
      lock_id_q <= sel;
      if (addr_hs) last_id_q <= sel;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (addr_hs),
    .pop_i   (fifo_pop),
    .id_i    (sel),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding is dropped; flag it in simulation.
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    s_rvalid_i |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_obi_bus_arbiter.sv
module tb_obi_bus_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_rready_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_rready_i;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, s_rready_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: queue of outstanding manager ids, round-robin pointer,
  // and the port whose address phase is waiting for a grant.
  int q[$];
  int last_id;
  bit held;
  int held_id;

  logic        exp_g0, exp_g1, exp_rv0, exp_rv1, exp_sreq, exp_rr, exp_we, exp_pop;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;
  int          exp_sel;

  obi_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rready_i(m0_rready_i), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rready_i(m1_rready_i), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rready_o(s_rready_o), .s_rdata_i(s_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [74:0] act_vec();
    return {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_req_o, s_rready_o,
            s_we_o, s_be_o, s_addr_o, s_wdata_o};
  endfunction

  function automatic logic [74:0] exp_vec();
    return {exp_g0, exp_g1, exp_rv0, exp_rv1, exp_sreq, exp_rr,
            exp_we, exp_be, exp_addr, exp_wdata};
  endfunction

  task automatic model_reset();
    q.delete();
    last_id = 1;
    held    = 1'b0;
    held_id = 0;
  endtask

  task automatic model_eval();
    bit empty, full, req_sel;
    int head, sel;
    empty = (q.size() == 0);
    full  = (q.size() >= MAXO);
    head  = empty ? 0 : q[0];
    exp_rr  = empty ? 1'b1 : ((head == 1) ? m1_rready_i : m0_rready_i);
    exp_pop = s_rvalid_i && exp_rr && !empty;
    if (held)                      sel = held_id;
    else if (m0_req_i && m1_req_i) sel = 1 - last_id;
    else if (m1_req_i)             sel = 1;
    else                           sel = 0;
    req_sel  = (sel == 1) ? m1_req_i : m0_req_i;
    exp_sreq = rst_n_i && req_sel && (!full || exp_pop);
    exp_g0   = s_gnt_i && exp_sreq && (sel == 0);
    exp_g1   = s_gnt_i && exp_sreq && (sel == 1);
    exp_rv0  = s_rvalid_i && !empty && (head == 0);
    exp_rv1  = s_rvalid_i && !empty && (head == 1);
    exp_addr  = !exp_sreq ? 32'h0 : ((sel == 1) ? m1_addr_i  : m0_addr_i);
    exp_wdata = !exp_sreq ? 32'h0 : ((sel == 1) ? m1_wdata_i : m0_wdata_i);
    exp_be    = !exp_sreq ? 4'h0  : ((sel == 1) ? m1_be_i    : m0_be_i);
    exp_we    = !exp_sreq ? 1'b0  : ((sel == 1) ? m1_we_i    : m0_we_i);
    exp_sel   = sel;
  endtask

  task automatic model_step();
    model_eval();
    if (rst_n_i) begin
      if (exp_pop) void'(q.pop_front());
      if (exp_sreq && s_gnt_i) begin
        q.push_back(exp_sel);
        last_id = exp_sel;
      end
      held    = exp_sreq && !s_gnt_i;
      held_id = exp_sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_i = 0; m0_addr_i = 0; m0_we_i = 0; m0_be_i = 0; m0_wdata_i = 0; m0_rready_i = 1;
    m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0; m1_be_i = 0; m1_wdata_i = 0; m1_rready_i = 1;
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 0;
  endtask

  task automatic test_reset();
    rst_n_i = 0;
    model_reset();
    idle_inputs();
    m0_req_i = 1; m0_addr_i = 32'h1234; m0_be_i = 4'hF; m0_wdata_i = 32'h77; m0_we_i = 1;
    m1_req_i = 1; m1_addr_i = 32'h5678; m1_be_i = 4'h3;
    s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'hDEAD_BEEF;
    #2;
    n_cmp++;
    if (act_vec() !== {6'b000001, 1'b0, 4'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", act_vec(), {6'b000001, 1'b0, 4'h0, 64'h0});
    end
    n_cmp++;
    if (m0_rdata_o !== 32'hDEAD_BEEF || m1_rdata_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h want deadbeef", m0_rdata_o, m1_rdata_o);
    end
    idle_inputs();
    @(negedge clk);
    rst_n_i = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_tie();
    idle_inputs();
    m0_req_i = 1; m0_addr_i = 32'h1000; m0_be_i = 4'hF; m0_wdata_i = 32'h11;
    m1_req_i = 1; m1_addr_i = 32'h2000; m1_be_i = 4'h3; m1_wdata_i = 32'h22; m1_we_i = 1;
    s_gnt_i = 1;
    #1; model_eval();
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o, s_addr_o} !== {2'b10, 32'h1000}) begin
      n_fail++;
      $display("FAIL tie_first: got gnt %b addr %h want 10 00001000", {m0_gnt_o, m1_gnt_o}, s_addr_o);
    end
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL tie_first_model: got %h want %h", act_vec(), exp_vec());
    end
    model_step();
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o, s_addr_o, s_we_o} !== {2'b01, 32'h2000, 1'b1}) begin
      n_fail++;
      $display("FAIL tie_second: got gnt %b addr %h we %b want 01 00002000 1", {m0_gnt_o, m1_gnt_o}, s_addr_o, s_we_o);
    end
    model_step();
    m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0;
    s_rvalid_i = 1; s_rdata_i = 32'hAAAA_0000;
    #1;
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== {2'b10, 32'hAAAA_0000}) begin
      n_fail++;
      $display("FAIL resp_first: got rv %b data %h want 10 aaaa0000", {m0_rvalid_o, m1_rvalid_o}, m0_rdata_o);
    end
    model_step();
    s_rdata_i = 32'h5555_1111;
    #1;
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o, m1_rdata_o} !== {2'b01, 32'h5555_1111}) begin
      n_fail++;
      $display("FAIL resp_second: got rv %b data %h want 01 55551111", {m0_rvalid_o, m1_rvalid_o}, m1_rdata_o);
    end
    model_step();
    s_rvalid_i = 0;
  endtask

  task automatic test_lock();
    idle_inputs();
    m1_req_i = 1; m1_addr_i = 32'h100; m1_be_i = 4'h1;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) begin m0_req_i = 1; m0_addr_i = 32'h200; end
      #1;
      n_cmp++;
      if ({s_req_o, m0_gnt_o, m1_gnt_o, s_addr_o} !== {3'b100, 32'h100}) begin
        n_fail++;
        $display("FAIL lock_hold%0d: got req/g0/g1 %b addr %h want 100 00000100", c, {s_req_o, m0_gnt_o, m1_gnt_o}, s_addr_o);
      end
      model_step();
    end
    s_gnt_i = 1;
    #1;
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o, s_addr_o} !== {2'b01, 32'h100}) begin
      n_fail++;
      $display("FAIL lock_grant: got gnt %b addr %h want 01 00000100", {m0_gnt_o, m1_gnt_o}, s_addr_o);
    end
    model_step();
    m1_req_i = 0;
    #1;
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o, s_addr_o} !== {2'b10, 32'h200}) begin
      n_fail++;
      $display("FAIL lock_after: got gnt %b addr %h want 10 00000200", {m0_gnt_o, m1_gnt_o}, s_addr_o);
    end
    model_step();
    m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1;
    #1;
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin
      n_fail++; $display("FAIL lock_resp1: got %b want 01", {m0_rvalid_o, m1_rvalid_o});
    end
    model_step();
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin
      n_fail++; $display("FAIL lock_resp2: got %b want 10", {m0_rvalid_o, m1_rvalid_o});
    end
    model_step();
    s_rvalid_i = 0;
  endtask

  task automatic test_full();
    idle_inputs();
    m0_req_i = 1; m0_addr_i = 32'h300; s_gnt_i = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({s_req_o, m0_gnt_o} !== ((c < MAXO) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL full_c%0d: got req/gnt %b want %b", c, {s_req_o, m0_gnt_o}, (c < MAXO) ? 2'b11 : 2'b00);
      end
      model_step();
    end
    s_rvalid_i = 1;
    #1;
    n_cmp++;
    if ({s_req_o, m0_gnt_o, m0_rvalid_o} !== 3'b111) begin
      n_fail++; $display("FAIL full_pop_push: got %b want 111", {s_req_o, m0_gnt_o, m0_rvalid_o});
    end
    model_step();
    m0_req_i = 0; s_gnt_i = 0;
    for (int c = 0; c < MAXO; c++) begin
      #1;
      n_cmp++;
      if (m0_rvalid_o !== 1'b1) begin
        n_fail++; $display("FAIL full_drain%0d: got %b want 1", c, m0_rvalid_o);
      end
      model_step();
    end
    s_rvalid_i = 0;
  endtask

  task automatic test_rready();
    idle_inputs();
    m1_req_i = 1; m1_addr_i = 32'h400; s_gnt_i = 1;
    #1;
    n_cmp++;
    if (m1_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_grant: got %b want 1", m1_gnt_o);
    end
    model_step();
    m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; m1_rready_i = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if ({s_rready_o, m1_rvalid_o, m0_rvalid_o} !== 3'b010) begin
        n_fail++; $display("FAIL rr_stall%0d: got %b want 010", c, {s_rready_o, m1_rvalid_o, m0_rvalid_o});
      end
      model_step();
    end
    m1_rready_i = 1;
    #1;
    n_cmp++;
    if ({s_rready_o, m1_rvalid_o} !== 2'b11) begin
      n_fail++; $display("FAIL rr_release: got %b want 11", {s_rready_o, m1_rvalid_o});
    end
    model_step();
    s_rvalid_i = 0; m0_rready_i = 0; m1_rready_i = 0;
    #1;
    n_cmp++;
    if (s_rready_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_empty: got %b want 1", s_rready_o);
    end
    model_step();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
    for (int c = 0; c < 2; c++) begin
      #1; model_eval();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rst_fill%0d: got %h want %h", c, act_vec(), exp_vec());
      end
      model_step();
    end
    s_gnt_i = 0;
    #3;
    rst_n_i = 0;
    model_reset();
    #1;
    n_cmp++;
    if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_async: got %b want 000", {s_req_o, m0_gnt_o, m1_gnt_o});
    end
    s_rvalid_i = 1; m0_rready_i = 0; m1_rready_i = 0;
    #1;
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o, s_rready_o} !== 3'b001) begin
      n_fail++; $display("FAIL rst_stray: got %b want 001", {m0_rvalid_o, m1_rvalid_o, s_rready_o});
    end
    s_rvalid_i = 0; m0_rready_i = 1; m1_rready_i = 1;
    @(negedge clk);
    rst_n_i = 1;
    @(posedge clk);
    #1;
    s_gnt_i = 1;
    #1;
    n_cmp++;
    if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b110) begin
      n_fail++; $display("FAIL rst_regrant: got %b want 110", {s_req_o, m0_gnt_o, m1_gnt_o});
    end
    model_step();
    m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1;
    #1;
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin
      n_fail++; $display("FAIL rst_resp: got %b want 10", {m0_rvalid_o, m1_rvalid_o});
    end
    model_step();
    s_rvalid_i = 0;
  endtask

  task automatic test_random();
    bit g0_prev, g1_prev;
    idle_inputs();
    g0_prev = 1; g1_prev = 1;
    for (int i = 0; i < 600; i++) begin
      // A manager with an ungranted request keeps it and its address stable.
      if (!(m0_req_i && !g0_prev)) begin
        m0_req_i = ($urandom_range(0, 2) != 0); m0_addr_i = $urandom;
        m0_we_i = $urandom_range(0, 1); m0_be_i = 4'($urandom); m0_wdata_i = $urandom;
      end
      if (!(m1_req_i && !g1_prev)) begin
        m1_req_i = ($urandom_range(0, 2) != 0); m1_addr_i = $urandom;
        m1_we_i = $urandom_range(0, 1); m1_be_i = 4'($urandom); m1_wdata_i = $urandom;
      end
      s_gnt_i     = ($urandom_range(0, 3) != 0);
      s_rvalid_i  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m0_rready_i = ($urandom_range(0, 4) != 0);
      m1_rready_i = ($urandom_range(0, 4) != 0);
      s_rdata_i   = $urandom;
      #1; model_eval();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand%0d: got %h want %h", i, act_vec(), exp_vec());
      end
      n_cmp++;
      if (m0_rdata_o !== s_rdata_i || m1_rdata_o !== s_rdata_i) begin
        n_fail++; $display("FAIL rand_rdata%0d: got %h/%h want %h", i, m0_rdata_o, m1_rdata_o, s_rdata_i);
      end
      g0_prev = exp_g0; g1_prev = exp_g1;
      model_step();
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_lock();
    test_full();
    test_rready();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
